// File: rtl/rr_arbiter4x4_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter4x4_if
// Bundles the requester lanes, the accept strobes and the result port of the
// 4-lane round-robin / merge arbiter.
//
// Handshake semantics (one place, applies to every signal below):
//   * Requester side: REQ[k] high means lane Ik carries valid data. The
//     requester keeps REQ[k] and Ik stable until it sees ACK[k] high, which
//     is a single-cycle combinational accept strobe. A lane whose REQ bit is
//     dropped before ACK is simply never accepted.
//   * Result side: O_VALID/O_READY is a strict valid/ready pair. O and GNT are
//     stable while O_VALID is high and are consumed on a rising clock edge
//     where O_VALID and O_READY are both high.
//
// Signals:
//   REQ      [3:0]        per-lane request            (requester -> arbiter)
//   I0..I3   [WIDTH-1:0]  lane data                   (requester -> arbiter)
//   MODE                  0 = round-robin, 1 = merge  (requester -> arbiter)
//   O_READY               downstream ready            (sink      -> arbiter)
//   ACK      [3:0]        accept strobe per lane      (arbiter   -> requester)
//   GNT      [3:0]        lanes captured into O       (arbiter   -> sink)
//   O        [WIDTH-1:0]  registered result           (arbiter   -> sink)
//   O_VALID               O holds an unconsumed result(arbiter   -> sink)
// ---------------------------------------------------------------------------
interface rr_arbiter4x4_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       REQ;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] I3;
  logic             MODE;
  logic             O_READY;
  logic [3:0]       ACK;
  logic [3:0]       GNT;
  logic [WIDTH-1:0] O;
  logic             O_VALID;

  // Environment side: requesters plus the downstream consumer.
  modport master (
    output REQ, I0, I1, I2, I3, MODE, O_READY,
    input  ACK, GNT, O, O_VALID
  );

  // Arbiter side.
  modport slave (
    input  REQ, I0, I1, I2, I3, MODE, O_READY,
    output ACK, GNT, O, O_VALID
  );
endinterface

// File: rtl/rr_arbiter4x4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4x4
// Four-requester arbiter with a single registered output slot.
//   MODE=0: exclusive round-robin grant. A 2-bit pointer names the highest
//           priority lane; after a grant it moves to the lane after the winner.
//   MODE=1: merge. Every requesting lane is accepted at once and O becomes the
//           bitwise OR of their data; the pointer is left untouched.
// A two-state FSM (IDLE/HOLD) owns the output slot: decisions are only made in
// IDLE, the result is held in HOLD until the sink takes it.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   ASYNCRESETN  active-low reset, asynchronous assertion, synchronous release
//   bus          rr_arbiter4x4_if.slave (REQ, I0..I3, MODE, O_READY in;
//                ACK, GNT, O, O_VALID out)
//   dbg_state    current FSM state (0 = IDLE, 1 = HOLD)
//   dbg_ptr      current round-robin priority pointer
// ---------------------------------------------------------------------------
module rr_arbiter4x4 #(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  rr_arbiter4x4_if.slave       bus,
  output logic                 dbg_state,
  output logic [1:0]           dbg_ptr
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [WIDTH-1:0] lane [4];
  logic [WIDTH-1:0] merge_data;
  logic [1:0]       win_idx;
  logic             win_found;
  logic [1:0]       scan_idx;
  logic [3:0]       ack_raw;

  assign lane[0] = bus.I0;
  assign lane[1] = bus.I1;
  assign lane[2] = bus.I2;
  assign lane[3] = bus.I3;

  // Round-robin search: first requesting lane starting at ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int j = 0; j < 4; j++) begin
      scan_idx = ptr_q + 2'(j);
      if (!win_found && bus.REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Merge data: only lanes that are actually requesting contribute.
  always_comb begin
    merge_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (bus.REQ[k]) begin
        merge_data = merge_data | lane[k];
      end
    end
  end

  // Next-state and accept decision.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    ack_raw = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ != 4'b0000) begin
          if (bus.MODE) begin
            ack_raw = bus.REQ;
            o_d     = merge_data;
            gnt_d   = bus.REQ;
          end else begin
            ack_raw = 4'b0001 << win_idx;
            o_d     = lane[win_idx];
            gnt_d   = 4'b0001 << win_idx;
            ptr_d   = win_idx + 2'd1;
          end
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // REQ and MODE are deliberately ignored here; only the sink matters.
        if (bus.O_READY) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ST_IDLE;
      o_q     <= '0;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // ACK is combinational from REQ; it must also be silent while reset is held,
  // since the FSM sits in IDLE during reset and would otherwise accept.
  assign bus.ACK     = ASYNCRESETN ? ack_raw : 4'b0000;
  assign bus.GNT     = gnt_q;
  assign bus.O       = o_q;
  assign bus.O_VALID = (state_q == ST_HOLD);

  assign dbg_state = (state_q == ST_HOLD);
  assign dbg_ptr   = ptr_q;

endmodule

// File: doc/rr_arbiter4x4.md
RR_ARBITER4X4 -- requirements
Module: rr_arbiter4x4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of each requester data lane and of O.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port ASYNCRESETN  input  1  reset, asynchronous assertion, active-low; deassertion is sampled synchronously to CLK.
REQ-004 The block SHALL have port REQ  input  4  per-requester request; REQ[k] high means lane Ik holds valid data.
REQ-005 The block SHALL have ports I0, I1, I2, I3  input  WIDTH each  requester data lanes.
REQ-006 The block SHALL have port MODE  input  1  0 = exclusive round-robin grant, 1 = merge (bitwise OR of all requesting lanes).
REQ-007 The block SHALL have port O_READY  input  1  downstream accepts O when high with O_VALID.
REQ-008 The block SHALL have port ACK  output  4  combinational one-cycle accept strobe per requester.
REQ-009 The block SHALL have port GNT  output  4  registered mask of the lanes captured into O.
REQ-010 The block SHALL have port O  output  WIDTH  registered result.
REQ-011 The block SHALL have port O_VALID  output  1  O holds an unconsumed result.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (O_VALID=0) and HOLD (O_VALID=1).
REQ-013 The block SHALL keep a 2-bit priority pointer PTR naming the highest-priority lane; search order is PTR, PTR+1, PTR+2, PTR+3, all mod 4.
REQ-014 In IDLE with MODE=0 and REQ!=0, the block SHALL select the first lane k in search order with REQ[k]=1 and SHALL drive ACK=onehot(k) in that same cycle.
REQ-015 On the edge ending that cycle, the block SHALL load O<=Ik, GNT<=onehot(k), PTR<=(k+1) mod 4, and enter HOLD.
REQ-016 In IDLE with MODE=1 and REQ!=0, the block SHALL drive ACK=REQ and, on the next edge, load O<=OR over all k with REQ[k]=1 of Ik, GNT<=REQ, and enter HOLD; PTR SHALL remain unchanged.
REQ-017 In IDLE with REQ=0, ACK SHALL be 0000 and O, GNT, and PTR SHALL hold their values.
REQ-018 In HOLD, ACK SHALL be 0000; O and GNT SHALL hold; REQ and MODE SHALL be ignored.
REQ-019 In HOLD with O_READY=1, the block SHALL return to IDLE on that edge, with O_VALID=0 and GNT<=0000 in the next cycle; O SHALL keep its last value.
REQ-020 In HOLD with O_READY=0, the block SHALL remain in HOLD indefinitely with O stable.
REQ-021 Latency SHALL be: request seen in IDLE at cycle t -> O_VALID=1 at t+1; peak throughput SHALL be one result per 2 cycles.
REQ-022 Requesters SHALL hold REQ[k] and Ik stable until ACK[k]; a requester that drops REQ before ACK SHALL NOT be granted and SHALL get no ACK.
REQ-023 MODE SHALL be sampled only in IDLE, in the same cycle as the ACK decision.
REQ-024 The block SHALL never grant a lane whose REQ bit is low, and ACK SHALL be exactly onehot or zero whenever MODE=0.

Reset
REQ-025 While ASYNCRESETN=0, the block SHALL immediately force state=IDLE, O=0, O_VALID=0, GNT=0000, PTR=0, and ACK=0000.
REQ-026 Reset asserted in HOLD SHALL discard the pending result without notifying the requester; no ACK SHALL be re-issued.
REQ-027 The first edge after deassertion SHALL behave as a normal IDLE cycle.

Verification
REQ-028 After reset, REQ=1111, MODE=0, O_READY=1 continuously, I0..I3=1,2,4,8 -> grants cycle lanes 0,1,2,3,0; O=1,2,4,8,1 on alternate cycles; ACK=0001,0010,0100,1000.
REQ-029 REQ=0101, MODE=1, I0=0011, I2=1000 -> ACK=0101 for one cycle; next cycle O=1011, GNT=0101, O_VALID=1; PTR unchanged.
REQ-030 Grant lane 2, then hold O_READY=0 for 5 cycles while REQ toggles -> O, GNT, and O_VALID stable; ACK=0000 throughout; O_READY=1 -> IDLE next cycle.
REQ-031 PTR=3 with REQ=1001 -> lane 3 granted first, then lane 0 (wrap-around).
REQ-032 ASYNCRESETN pulsed low mid-HOLD, between clock edges -> O, O_VALID, and GNT clear without waiting for an edge; the next grant starts from lane 0.
REQ-033 REQ[1] asserted then dropped before ACK while lane 0 is held in HOLD -> lane 1 is never acknowledged.
